// File: rtl/pll_reset_ctrl.sv
// PLL lock supervisor and system reset sequencer.
// Runs on the free-running TCXO clock, never on a PLL output.
module pll_reset_ctrl #(
    parameter int unsigned pll_rst_cycles      = 16,
    parameter int unsigned lock_timeout_cycles = 4096,
    parameter int unsigned lock_stable_cycles  = 256,
    parameter int unsigned max_attempts        = 3
) (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic       i_locked,
    output logic       o_pll_reset,
    output logic       o_sys_nrst,
    output logic       o_ready,
    output logic       o_fault,
    output logic [3:0] o_attempts,
    output logic [7:0] o_lock_loss_cnt
);

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } state_t;

    localparam logic [15:0] RST_LAST = 16'(pll_rst_cycles - 1);
    localparam logic [15:0] TO_LAST  = 16'(lock_timeout_cycles - 1);
    localparam logic [15:0] ST_LAST  = 16'(lock_stable_cycles - 1);
    localparam logic [3:0]  ATT_MAX  = 4'(max_attempts);

    state_t      state;
    state_t      state_n;
    logic [15:0] cnt;
    logic [15:0] cnt_n;
    logic [3:0]  att_n;
    logic [7:0]  loss_n;
    logic        sync_q;
    logic        locked_s;

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 16'd1;
        att_n   = o_attempts;
        loss_n  = o_lock_loss_cnt;
        unique case (state)
            PLL_RST: begin
                if (cnt == RST_LAST) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_n = STABLE;
                    cnt_n   = '0;
                end else if (cnt == TO_LAST) begin
                    att_n   = o_attempts + 4'd1;
                    cnt_n   = '0;
                    state_n = (att_n == ATT_MAX) ? FAULT : PLL_RST;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt == ST_LAST) begin
                    state_n = RUN;
                    cnt_n   = '0;
                    att_n   = '0;
                end
            end
            RUN: begin
                cnt_n = '0;
                if (!locked_s) begin
                    state_n = PLL_RST;
                    if (o_lock_loss_cnt != 8'hff)
                        loss_n = o_lock_loss_cnt + 8'd1;
                end
            end
            FAULT: begin
                cnt_n = '0;
            end
            // Corrupted encodings fall back to a fresh PLL reset.
            default: begin
                state_n = PLL_RST;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            sync_q          <= 1'b0;
            locked_s        <= 1'b0;
            state           <= PLL_RST;
            cnt             <= '0;
            o_attempts      <= '0;
            o_lock_loss_cnt <= '0;
            o_pll_reset     <= 1'b1;
            o_sys_nrst      <= 1'b0;
            o_ready         <= 1'b0;
            o_fault         <= 1'b0;
        end else begin
            sync_q          <= i_locked;
            locked_s        <= sync_q;
            state           <= state_n;
            cnt             <= cnt_n;
            o_attempts      <= att_n;
            o_lock_loss_cnt <= loss_n;
            o_pll_reset     <= (state_n == PLL_RST) || (state_n == FAULT);
            o_sys_nrst      <= (state_n == RUN);
            o_ready         <= (state_n == RUN);
            o_fault         <= (state_n == FAULT);
        end
    end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl.
// Edge 0 is the first rising edge that samples i_nrst=1.
module tb_pll_reset_ctrl;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       locked = 1'b0;
    logic       pll_reset;
    logic       sys_nrst;
    logic       ready;
    logic       fault;
    logic [3:0] attempts;
    logic [7:0] loss_cnt;

    int total = 0;
    int bad = 0;
    int e = -1;

    pll_reset_ctrl #(
        .pll_rst_cycles(4),
        .lock_timeout_cycles(20),
        .lock_stable_cycles(8),
        .max_attempts(3)
    ) dut (
        .i_clk(clk),
        .i_nrst(nrst),
        .i_locked(locked),
        .o_pll_reset(pll_reset),
        .o_sys_nrst(sys_nrst),
        .o_ready(ready),
        .o_fault(fault),
        .o_attempts(attempts),
        .o_lock_loss_cnt(loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic step_to(input int k);
        while (e < k) step();
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        locked = 1'b0;
        step();
        step();
        nrst = 1'b1;
        e = -1;
    endtask

    task automatic wait_sys(input logic val, input int bound, input string tag);
        int n;
        n = 0;
        while (sys_nrst !== val && n < bound) begin
            step();
            n++;
        end
        chk(tag, 32'(sys_nrst), 32'(val));
    endtask

    initial begin
        int rel;
        int held;

        // Nominal lock
        do_reset();
        chk("rst_pll", 32'(pll_reset), 1);
        chk("rst_sys", 32'(sys_nrst), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_att", 32'(attempts), 0);
        chk("rst_loss", 32'(loss_cnt), 0);
        step_to(2);
        chk("nom_pll_hi", 32'(pll_reset), 1);
        step_to(3);
        chk("nom_pll_lo", 32'(pll_reset), 0);
        step_to(9);
        locked = 1'b1;
        step_to(19);
        chk("nom_sys_early", 32'(sys_nrst), 0);
        step_to(20);
        chk("nom_sys", 32'(sys_nrst), 1);
        chk("nom_ready", 32'(ready), 1);
        chk("nom_att", 32'(attempts), 0);

        // Lock loss in RUN, one-cycle drop sampled at edge 30
        step_to(29);
        locked = 1'b0;
        step_to(30);
        locked = 1'b1;
        step_to(31);
        chk("loss_sys_hold", 32'(sys_nrst), 1);
        step_to(32);
        chk("loss_sys_drop", 32'(sys_nrst), 0);
        chk("loss_pll", 32'(pll_reset), 1);
        chk("loss_cnt1", 32'(loss_cnt), 1);
        step_to(44);
        chk("loss_reseq_early", 32'(sys_nrst), 0);
        step_to(45);
        chk("loss_reseq_run", 32'(sys_nrst), 1);

        // Second loss, then reset while in STABLE
        step_to(49);
        locked = 1'b0;
        step_to(50);
        locked = 1'b1;
        step_to(58);
        chk("loss_cnt2", 32'(loss_cnt), 2);
        chk("stable_pll", 32'(pll_reset), 0);
        nrst = 1'b0;
        step();
        chk("mid_rst_pll", 32'(pll_reset), 1);
        chk("mid_rst_sys", 32'(sys_nrst), 0);
        chk("mid_rst_fault", 32'(fault), 0);
        chk("mid_rst_att", 32'(attempts), 0);
        chk("mid_rst_loss", 32'(loss_cnt), 0);

        // Never locks
        do_reset();
        step_to(22);
        chk("nl_pll_lo", 32'(pll_reset), 0);
        chk("nl_att0", 32'(attempts), 0);
        step_to(23);
        chk("nl_pll2", 32'(pll_reset), 1);
        chk("nl_att1", 32'(attempts), 1);
        step_to(26);
        chk("nl_pll2_hi", 32'(pll_reset), 1);
        step_to(27);
        chk("nl_pll2_lo", 32'(pll_reset), 0);
        step_to(46);
        chk("nl_att1_hold", 32'(attempts), 1);
        step_to(47);
        chk("nl_att2", 32'(attempts), 2);
        chk("nl_pll3", 32'(pll_reset), 1);
        step_to(70);
        chk("nl_fault_early", 32'(fault), 0);
        step_to(71);
        chk("nl_fault", 32'(fault), 1);
        chk("nl_att3", 32'(attempts), 3);
        chk("nl_fault_pll", 32'(pll_reset), 1);
        chk("nl_fault_sys", 32'(sys_nrst), 0);
        held = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (fault === 1'b1 && pll_reset === 1'b1 && sys_nrst === 1'b0)
                held++;
        end
        chk("nl_fault_hold", 32'(held), 200);

        // Reset out of FAULT
        nrst = 1'b0;
        step();
        chk("frst_fault", 32'(fault), 0);
        chk("frst_pll", 32'(pll_reset), 1);
        chk("frst_sys", 32'(sys_nrst), 0);
        chk("frst_att", 32'(attempts), 0);
        chk("frst_loss", 32'(loss_cnt), 0);

        // Unstable lock: high 5, low 3, high from edge 18
        do_reset();
        rel = 0;
        for (int k = 0; k <= 27; k++) begin
            if (k == 10) locked = 1'b1;
            if (k == 15) locked = 1'b0;
            if (k == 18) locked = 1'b1;
            step();
            if (sys_nrst !== 1'b0) rel++;
        end
        chk("unst_no_early", 32'(rel), 0);
        step_to(28);
        chk("unst_sys", 32'(sys_nrst), 1);
        chk("unst_att", 32'(attempts), 0);

        // Saturation of the lock-loss counter
        do_reset();
        locked = 1'b1;
        wait_sys(1'b1, 60, "sat_first_run");
        for (int i = 0; i < 260; i++) begin
            locked = 1'b0;
            step();
            locked = 1'b1;
            wait_sys(1'b0, 10, "sat_drop");
            wait_sys(1'b1, 40, "sat_rerun");
            if (i == 0) chk("sat_cnt1", 32'(loss_cnt), 1);
            if (i == 254) chk("sat_cnt255", 32'(loss_cnt), 255);
        end
        chk("sat_cnt_end", 32'(loss_cnt), 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
